riscv_decode_pipe: RTL and testbench
====================================

RISCV_DECODE_PIPE -- requirements
Module: riscv_decode_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, legal values 32/64; width of pc and imm.
REQ-002 SHALL have parameter RV64_OPS, default (XLEN==64), enabling the OP-32 and OP-IMM-32 opcodes.
REQ-003 SHALL have parameter CNT_W, default 32, width of the decoded-instruction counter.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous; discards all buffered instructions.
REQ-007 in_valid / in_ready  input / output  1 / 1  upstream handshake.
REQ-008 in_insn, in_pc  input  32, XLEN  instruction word and its PC.
REQ-009 out_valid / out_ready  output / input  1 / 1  downstream handshake.
REQ-010 out_opcode 7, out_rd/out_rs1/out_rs2 5, out_funct3 3, out_funct7 7  output  decoded fields.
REQ-011 out_imm  output  XLEN  sign-extended immediate.
REQ-012 out_fmt  output  3  format code from package (R, I, S, B, U, J).
REQ-013 out_illegal, out_pc  output  1, XLEN  illegal flag; PC passed through.
REQ-014 dec_count  output  CNT_W  saturating count of instructions accepted downstream.

Function
REQ-015 Transfer occurs on a cycle with valid and ready both high; no transfer otherwise.
REQ-016 Decode is combinational on in_insn; result is registered; latency in->out is 1 cycle when out_ready is high.
REQ-017 Two-entry skid buffer: in_ready is a register output, low only when both entries are held.
REQ-018 Full throughput: 1 insn/cycle sustained while out_ready is high.
REQ-019 Order preserved; no drop, no duplicate under any out_ready pattern.
REQ-020 Outputs SHALL stay stable while out_valid is high and out_ready is low.
REQ-021 Fields: rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25], always extracted irrespective of format.
REQ-022 Format map: OP, OP-32 -> R; OP-IMM, OP-IMM-32, LOAD, JALR, SYSTEM, MISC-MEM -> I; STORE -> S; BRANCH -> B; LUI, AUIPC -> U; JAL -> J.
REQ-023 Immediates: I [31:20]; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0}; U {[31:12],12'b0}; J {[31],[19:12],[20],[30:21],0}; all sign-extended from bit 31 to XLEN; R -> 0.
REQ-024 out_illegal=1 when insn[1:0]!=2'b11, opcode unmapped, or OP-32/OP-IMM-32 with RV64_OPS=0; then fmt=R, imm=0, instruction still passed downstream.
REQ-025 flush: both entries invalidated next cycle; out_valid=0, in_ready=1; an input handshake in the flush cycle is discarded.
REQ-026 flush with simultaneous output handshake: output transfer counts as completed (dec_count increments).
REQ-027 dec_count increments per output transfer, saturates at all-ones, never wraps.

Reset
REQ-028 Reset asserted: out_valid=0, in_ready=0 while rst_n low, dec_count=0, buffer entries invalid.
REQ-029 Data outputs (fields, imm, fmt, illegal, pc) SHALL reset to 0.
REQ-030 in_ready SHALL rise on the first clock edge after rst_n deassertion; reset mid-stream loses all held instructions.

Structure
REQ-031 Package riscv_decode_pkg SHALL hold opcode constants, fmt enum, and the decoded-instruction packed struct.
REQ-032 Skid buffer SHALL be a separate parametrised sub-module pipe_skid_buf, type-agnostic over payload width.
REQ-033 Decode logic SHALL be one combinational function/always block in riscv_decode_pipe.

Verification
REQ-034 0xFFF00093 (addi x1,x0,-1), XLEN=64 -> fmt I, rd=1, rs1=0, imm=0xFFFF_FFFF_FFFF_FFFF, illegal=0, 1 cycle later.
REQ-035 0xFE000EE3 (beq x0,x0,-4) -> fmt B, imm=-4 sign-extended; 0x123452B7 (lui x5,0x12345) -> fmt U, rd=5, imm=0x12345000.
REQ-036 0x0000003B (addw) with XLEN=32 -> illegal=1, imm=0; with XLEN=64 -> fmt R, illegal=0.
REQ-037 Stream 5 insns, out_ready low cycles 2-4 -> in_ready low after 2 held, all 5 emitted in order, dec_count=5.
REQ-038 flush with 2 held entries and in_valid high -> next cycle out_valid=0, in_ready=1, dec_count unchanged.
REQ-039 rst_n pulsed low mid-stream -> outputs 0 asynchronously, in_ready=1 one edge after release; CNT_W=3 run of 9 transfers -> dec_count=7.

Source files
------------

// File: rtl/riscv_decode_pkg.sv
// Shared opcode constants, format codes and the decoded-instruction record
// used by the RV32I/RV64I decode pipeline stage.
package riscv_decode_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    // Immediate and PC are XLEN-wide and travel beside this record in the payload.
    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [6:0] funct7;
        fmt_e       fmt;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/riscv_decode_pipe_skid_buf.sv
// Two-entry skid buffer with a registered in_ready; payload is an opaque bit
// vector so any record can be carried.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         r_out_valid;
    logic         r_skid_valid;
    logic         r_in_ready;
    logic [W-1:0] r_out_data;
    logic [W-1:0] r_skid_data;

    logic         w_in_fire;
    logic         w_out_fire;
    logic         w_out_valid_n;
    logic         w_skid_valid_n;
    logic         w_in_ready_n;
    logic [W-1:0] w_out_data_n;
    logic [W-1:0] w_skid_data_n;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    // Next-state: the output slot always holds the oldest entry, the skid slot the younger one.
    always_comb begin
        w_out_valid_n  = r_out_valid;
        w_skid_valid_n = r_skid_valid;
        w_out_data_n   = r_out_data;
        w_skid_data_n  = r_skid_data;
        if (flush) begin
            w_out_valid_n  = 1'b0;
            w_skid_valid_n = 1'b0;
        end else if (!r_out_valid || w_out_fire) begin
            if (r_skid_valid) begin
                w_out_valid_n  = 1'b1;
                w_out_data_n   = r_skid_data;
                w_skid_valid_n = 1'b0;
            end else if (w_in_fire) begin
                w_out_valid_n = 1'b1;
                w_out_data_n  = in_data;
            end else begin
                w_out_valid_n = 1'b0;
            end
        end else if (w_in_fire) begin
            w_skid_valid_n = 1'b1;
            w_skid_data_n  = in_data;
        end else begin
            w_skid_valid_n = r_skid_valid;
        end
        w_in_ready_n = !(w_out_valid_n && w_skid_valid_n);
    end

    // State registers; in_ready stays low through reset and rises on the first edge after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
            r_out_data   <= {W{1'b0}};
            r_skid_data  <= {W{1'b0}};
        end else begin
            r_out_valid  <= w_out_valid_n;
            r_skid_valid <= w_skid_valid_n;
            r_in_ready   <= w_in_ready_n;
            r_out_data   <= w_out_data_n;
            r_skid_data  <= w_skid_data_n;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: rtl/riscv_decode_pipe.sv
// RISC-V instruction decode stage: combinational field/immediate decode feeding
// a two-entry skid buffer, plus a saturating count of delivered instructions.
module riscv_decode_pipe
    import riscv_decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit RV64_OPS = (XLEN == 64),
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_insn,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [XLEN-1:0]  out_pc,
    output logic [CNT_W-1:0] dec_count
);

    localparam int W_PAY = $bits(dec_t) + 2 * XLEN;

    dec_t              w_dec;
    fmt_e              w_fmt_raw;
    logic              w_bad;
    logic [31:0]       w_imm32;
    logic [XLEN-1:0]   w_imm;
    logic [W_PAY-1:0]  w_in_payload;
    logic [W_PAY-1:0]  w_out_payload;
    dec_t              w_out_dec;
    logic [XLEN-1:0]   w_out_imm;
    logic [XLEN-1:0]   w_out_pc;
    logic              w_out_valid;
    logic              w_out_fire;
    logic [CNT_W-1:0]  r_dec_count;

    // Decode: format from opcode, then the immediate of that format sign-extended to XLEN.
    always_comb begin
        w_dec.opcode  = in_insn[6:0];
        w_dec.rd      = in_insn[11:7];
        w_dec.funct3  = in_insn[14:12];
        w_dec.rs1     = in_insn[19:15];
        w_dec.rs2     = in_insn[24:20];
        w_dec.funct7  = in_insn[31:25];
        w_dec.fmt     = FMT_R;
        w_dec.illegal = 1'b0;
        w_fmt_raw     = FMT_R;
        w_bad         = 1'b0;
        w_imm32       = 32'd0;
        case (in_insn[6:0])
            OPC_OP: begin
                w_fmt_raw = FMT_R;
            end
            OPC_OP_32: begin
                if (RV64_OPS) begin
                    w_fmt_raw = FMT_R;
                end else begin
                    w_bad = 1'b1;
                end
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: begin
                w_fmt_raw = FMT_I;
            end
            OPC_OP_IMM_32: begin
                if (RV64_OPS) begin
                    w_fmt_raw = FMT_I;
                end else begin
                    w_bad = 1'b1;
                end
            end
            OPC_STORE:           w_fmt_raw = FMT_S;
            OPC_BRANCH:          w_fmt_raw = FMT_B;
            OPC_LUI, OPC_AUIPC:  w_fmt_raw = FMT_U;
            OPC_JAL:             w_fmt_raw = FMT_J;
            default:             w_bad     = 1'b1;
        endcase
        if (w_bad || (in_insn[1:0] != 2'b11)) begin
            w_dec.fmt     = FMT_R;
            w_dec.illegal = 1'b1;
            w_imm32       = 32'd0;
        end else begin
            w_dec.fmt     = w_fmt_raw;
            w_dec.illegal = 1'b0;
            case (w_fmt_raw)
                FMT_I:   w_imm32 = {{20{in_insn[31]}}, in_insn[31:20]};
                FMT_S:   w_imm32 = {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
                FMT_B:   w_imm32 = {{19{in_insn[31]}}, in_insn[31], in_insn[7],
                                    in_insn[30:25], in_insn[11:8], 1'b0};
                FMT_U:   w_imm32 = {in_insn[31:12], 12'd0};
                FMT_J:   w_imm32 = {{11{in_insn[31]}}, in_insn[31], in_insn[19:12],
                                    in_insn[20], in_insn[30:21], 1'b0};
                default: w_imm32 = 32'd0;
            endcase
        end
        w_imm = XLEN'($signed(w_imm32));
    end

    assign w_in_payload = {in_pc, w_imm, w_dec};

    pipe_skid_buf #(
        .W (W_PAY)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_payload),
        .out_valid (w_out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_payload)
    );

    assign {w_out_pc, w_out_imm, w_out_dec} = w_out_payload;
    assign w_out_fire = w_out_valid & out_ready;

    // Delivered-instruction counter; a transfer in a flush cycle still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec_count <= {CNT_W{1'b0}};
        end else if (w_out_fire && (r_dec_count != {CNT_W{1'b1}})) begin
            r_dec_count <= r_dec_count + CNT_W'(1);
        end else begin
            r_dec_count <= r_dec_count;
        end
    end

    assign out_valid   = w_out_valid;
    assign out_opcode  = w_out_dec.opcode;
    assign out_rd      = w_out_dec.rd;
    assign out_rs1     = w_out_dec.rs1;
    assign out_rs2     = w_out_dec.rs2;
    assign out_funct3  = w_out_dec.funct3;
    assign out_funct7  = w_out_dec.funct7;
    assign out_imm     = w_out_imm;
    assign out_fmt     = w_out_dec.fmt;
    assign out_illegal = w_out_dec.illegal;
    assign out_pc      = w_out_pc;
    assign dec_count   = r_dec_count;

endmodule

// File: tb/tb_riscv_decode_pipe.sv
// Scoreboard bench: one RV64 instance and one RV32 instance (3-bit counter)
// driven in lockstep, expected decode pushed on accept and compared while held.
module tb_riscv_decode_pipe;
    import riscv_decode_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_insn;
    logic [63:0] in_pc;
    logic        out_ready;

    logic        r64, v64, ill64;
    logic [6:0]  opc64, f7_64;
    logic [4:0]  rd64, rs1_64, rs2_64;
    logic [2:0]  f3_64, fmt64;
    logic [63:0] imm64, pc64;
    logic [31:0] cnt64;

    logic        r32, v32, ill32;
    logic [6:0]  opc32, f7_32;
    logic [4:0]  rd32, rs1_32, rs2_32;
    logic [2:0]  f3_32, fmt32;
    logic [31:0] imm32, pc32;
    logic [2:0]  cnt32;

    typedef struct packed {
        logic [31:0] insn;
        logic [63:0] pc;
        logic        ill64;
        logic        ill32;
        logic [2:0]  fmt64;
        logic [2:0]  fmt32;
        logic [63:0] imm64;
        logic [31:0] imm32;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   failures;
    int   n_xfer;

    riscv_decode_pipe #(.XLEN(64), .CNT_W(32)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r64),
        .in_insn(in_insn), .in_pc(in_pc), .out_valid(v64), .out_ready(out_ready),
        .out_opcode(opc64), .out_rd(rd64), .out_rs1(rs1_64), .out_rs2(rs2_64),
        .out_funct3(f3_64), .out_funct7(f7_64), .out_imm(imm64), .out_fmt(fmt64),
        .out_illegal(ill64), .out_pc(pc64), .dec_count(cnt64)
    );

    riscv_decode_pipe #(.XLEN(32), .CNT_W(3)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r32),
        .in_insn(in_insn), .in_pc(in_pc[31:0]), .out_valid(v32), .out_ready(out_ready),
        .out_opcode(opc32), .out_rd(rd32), .out_rs1(rs1_32), .out_rs2(rs2_32),
        .out_funct3(f3_32), .out_funct7(f7_32), .out_imm(imm32), .out_fmt(fmt32),
        .out_illegal(ill32), .out_pc(pc32), .dec_count(cnt32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decoder written directly against the ISA encoding tables.
    function automatic void model(input logic [31:0] insn, input bit rv64,
                                  output logic ill, output logic [2:0] fmt,
                                  output logic [63:0] imm);
        fmt_e f;
        logic bad;
        f   = FMT_R;
        bad = 1'b0;
        case (insn[6:0])
            7'h33: f = FMT_R;
            7'h3B: if (!rv64) bad = 1'b1; else f = FMT_R;
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: f = FMT_I;
            7'h1B: if (!rv64) bad = 1'b1; else f = FMT_I;
            7'h23: f = FMT_S;
            7'h63: f = FMT_B;
            7'h37, 7'h17: f = FMT_U;
            7'h6F: f = FMT_J;
            default: bad = 1'b1;
        endcase
        if (insn[1:0] != 2'b11) bad = 1'b1;
        ill = bad;
        fmt = bad ? FMT_R : f;
        imm = 64'd0;
        if (!bad) begin
            case (f)
                FMT_I: imm = {{52{insn[31]}}, insn[31:20]};
                FMT_S: imm = {{52{insn[31]}}, insn[31:25], insn[11:7]};
                FMT_B: imm = {{51{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
                FMT_U: imm = {{32{insn[31]}}, insn[31:12], 12'd0};
                FMT_J: imm = {{43{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
                default: imm = 64'd0;
            endcase
        end
    endfunction

    function automatic exp_t make_exp(input logic [31:0] insn, input logic [63:0] pc);
        exp_t e;
        logic [63:0] i32w;
        e.insn = insn;
        e.pc   = pc;
        model(insn, 1'b1, e.ill64, e.fmt64, e.imm64);
        model(insn, 1'b0, e.ill32, e.fmt32, i32w);
        e.imm32 = i32w[31:0];
        return e;
    endfunction

    // One clock: drive, check held state against the scoreboard, update model, advance.
    task automatic step(input logic v, input logic [31:0] insn, input logic [63:0] pc,
                        input logic rdy, input logic fl);
        exp_t e;
        logic [31:0] fld;
        in_valid = v; in_insn = insn; in_pc = pc; out_ready = rdy; flush = fl;
        chk("in_ready64", 64'(r64), 64'(q.size() < 2));
        chk("in_ready32", 64'(r32), 64'(q.size() < 2));
        chk("out_valid64", 64'(v64), 64'(q.size() != 0));
        chk("out_valid32", 64'(v32), 64'(q.size() != 0));
        if (q.size() != 0) begin
            e = q[0];
            fld = {e.insn[6:0], e.insn[11:7], e.insn[14:12], e.insn[19:15], e.insn[24:20], e.insn[31:25]};
            chk("fields64", 64'({opc64, rd64, f3_64, rs1_64, rs2_64, f7_64}), 64'(fld));
            chk("fields32", 64'({opc32, rd32, f3_32, rs1_32, rs2_32, f7_32}), 64'(fld));
            chk("fmt64", 64'(fmt64), 64'(e.fmt64));
            chk("fmt32", 64'(fmt32), 64'(e.fmt32));
            chk("illegal64", 64'(ill64), 64'(e.ill64));
            chk("illegal32", 64'(ill32), 64'(e.ill32));
            chk("imm64", imm64, e.imm64);
            chk("imm32", 64'(imm32), 64'(e.imm32));
            chk("pc64", pc64, e.pc);
            chk("pc32", 64'(pc32), 64'(e.pc[31:0]));
        end
        if (v64 && rdy) begin
            if (q.size() != 0) void'(q.pop_front());
            n_xfer++;
        end
        if (fl) q.delete();
        else if (v && r64) q.push_back(make_exp(insn, pc));
        @(posedge clk); #1;
        chk("dec_count64", 64'(cnt64), 64'(n_xfer));
        chk("dec_count32", 64'(cnt32), 64'((n_xfer > 7) ? 7 : n_xfer));
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_valid64", 64'(v64), 64'd0);
        chk("rst_valid32", 64'(v32), 64'd0);
        chk("rst_ready64", 64'(r64), 64'd0);
        chk("rst_ready32", 64'(r32), 64'd0);
        chk("rst_fields64", 64'({opc64, rd64, f3_64, rs1_64, rs2_64, f7_64, fmt64, ill64}), 64'd0);
        chk("rst_fields32", 64'({opc32, rd32, f3_32, rs1_32, rs2_32, f7_32, fmt32, ill32}), 64'd0);
        chk("rst_imm64", imm64, 64'd0);
        chk("rst_pc64", pc64, 64'd0);
        chk("rst_immpc32", {imm32, pc32}, 64'd0);
        chk("rst_cnt", 64'({cnt64, cnt32}), 64'd0);
        q.delete();
        n_xfer = 0;
        @(posedge clk); #1;
        chk("rst_hold_ready64", 64'(r64), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_ready64", 64'(r64), 64'd1);
        chk("rel_ready32", 64'(r32), 64'd1);
        chk("rel_valid64", 64'(v64), 64'd0);
    endtask

    localparam logic [31:0] DIR_INSN [16] = '{
        32'hFFF00093, 32'hFE000EE3, 32'h123452B7, 32'h0000003B,
        32'h0010009B, 32'hFF9FF0EF, 32'h000080E7, 32'h00001517,
        32'hFFC12083, 32'hFE112E23, 32'h00000073, 32'h0FF0000F,
        32'h40208133, 32'h00000010, 32'h0000007F, 32'h00112623
    };

    initial begin
        int base;
        int idx;
        bit saw_full;
        checks = 0; failures = 0; n_xfer = 0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_insn = 32'd0;
        in_pc = 64'd0; out_ready = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // Directed decode, back to back with out_ready high.
        for (int i = 0; i < 16; i++)
            step(1'b1, DIR_INSN[i], 64'h8000_0000_0000_1000 + 64'(i * 4), 1'b1, 1'b0);
        step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        chk("dir_count", 64'(cnt64), 64'd16);

        // Five-instruction stream with out_ready low on cycles 2-4.
        base = n_xfer; idx = 0; saw_full = 1'b0;
        for (int c = 0; c < 40 && idx < 5; c++) begin
            if (!r64) saw_full = 1'b1;
            if (r64) begin
                step(1'b1, DIR_INSN[idx], 64'h2000 + 64'(idx * 4), !(c >= 2 && c <= 4), 1'b0);
                idx++;
            end else begin
                step(1'b1, DIR_INSN[idx], 64'h2000 + 64'(idx * 4), !(c >= 2 && c <= 4), 1'b0);
            end
        end
        for (int c = 0; c < 10 && q.size() != 0; c++)
            step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        chk("stream_full_seen", 64'(saw_full), 64'd1);
        chk("stream_drained", 64'(q.size()), 64'd0);
        chk("stream_count", 64'(n_xfer - base), 64'd5);

        // Flush with both entries held and in_valid high.
        step(1'b1, 32'h00100093, 64'h3000, 1'b0, 1'b0);
        step(1'b1, 32'h00200113, 64'h3004, 1'b0, 1'b0);
        base = n_xfer;
        step(1'b1, 32'h00300193, 64'h3008, 1'b0, 1'b1);
        step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        chk("flush_valid", 64'(v64), 64'd0);
        chk("flush_cnt", 64'(cnt64), 64'(base));

        // Flush coinciding with an output transfer and an input handshake.
        step(1'b1, 32'h00400213, 64'h4000, 1'b0, 1'b0);
        base = n_xfer;
        step(1'b1, 32'h00500293, 64'h4004, 1'b1, 1'b1);
        chk("flush_xfer_cnt", 64'(cnt64), 64'(base + 1));
        step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);

        // Reset mid-stream with entries held.
        step(1'b1, 32'h00600313, 64'h5000, 1'b0, 1'b0);
        step(1'b1, 32'h00700393, 64'h5004, 1'b0, 1'b0);
        do_reset();

        // Nine transfers: the 3-bit counter saturates at 7.
        for (int i = 0; i < 9; i++)
            step(1'b1, DIR_INSN[i], 64'h6000 + 64'(i * 4), 1'b1, 1'b0);
        step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        chk("sat_cnt32", 64'(cnt32), 64'd7);
        chk("sat_cnt64", 64'(cnt64), 64'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
